// File: rtl/trng_pkg.sv
// Shared constants and pair-phase type for the ring-oscillator TRNG blocks.
package trng_pkg;

    localparam int TRNG_N          = 10;
    localparam int TRNG_OUT_W      = 8;
    localparam int TRNG_REP_CUTOFF = 32;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } pair_phase_e;

endpackage

// File: rtl/von_neumann_corrector.sv
// Von Neumann debiaser: pairs consecutive strobed raw bits, emits first bit of a 01/10 pair.
// Emit is combinational on the SECOND sample; a low strobe returns the phase to FIRST.
module von_neumann_corrector
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic raw_bit,
    input  logic sample_vld,
    output logic emit_vld,
    output logic emit_bit
);

    pair_phase_e phase_q, phase_d;
    logic        first_q, first_d;

    always_comb begin
        phase_d  = PH_FIRST;
        first_d  = first_q;
        emit_vld = 1'b0;
        emit_bit = first_q;
        if (sample_vld) begin
            if (phase_q == PH_FIRST) begin
                phase_d = PH_SECOND;
                first_d = raw_bit;
            end else begin
                phase_d  = PH_FIRST;
                emit_vld = (first_q != raw_bit);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_FIRST;
            first_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/ro_entropy_collector.sv
// Ring-oscillator entropy collector: synchronize, XOR, debias, pack into OUT_W-bit words.
// Optional repetition-count health test enabled by defining RO_TRNG_HEALTH_EN.
module ro_entropy_collector
    import trng_pkg::*;
#(
    parameter int N          = TRNG_N,
    parameter int OUT_W      = TRNG_OUT_W,
    parameter int REP_CUTOFF = TRNG_REP_CUTOFF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic [N-1:0]     RO_IN,
    output logic [OUT_W-1:0] DATA_OUT,
    output logic             DATA_VALID,
    input  logic             DATA_READY,
    output logic             HEALTH_FAIL
);

    localparam int CNT_W = $clog2(OUT_W + 1);

    logic [N-1:0]     sync1_q, sync1_d;
    logic [N-1:0]     sync2_q, sync2_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             dvld_q, dvld_d;

    logic raw_bit;
    logic emit_vld;
    logic emit_bit;
    logic health_fail;
    logic handshake;
    logic out_free;
    logic acc_full;
    logic transfer;
    logic accept_bit;

    assign sync1_d = RO_IN;
    assign sync2_d = sync1_q;
    assign raw_bit = ^sync2_q;

    von_neumann_corrector u_vnc (
        .clk        (CLK),
        .rst        (RST),
        .raw_bit    (raw_bit),
        .sample_vld (ENABLE),
        .emit_vld   (emit_vld),
        .emit_bit   (emit_bit)
    );

`ifdef RO_TRNG_HEALTH_EN
    localparam int REP_W = $clog2(REP_CUTOFF + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_bit_q, rep_bit_d;
    logic             fail_q, fail_d;

    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_bit_d = rep_bit_q;
        fail_d    = fail_q;
        if (ENABLE && !fail_q) begin
            if ((rep_cnt_q != '0) && (raw_bit == rep_bit_q)) begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end else begin
                rep_cnt_d = REP_W'(1);
            end
            rep_bit_d = raw_bit;
            if (rep_cnt_d == REP_W'(REP_CUTOFF)) begin
                fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rep_cnt_q <= '0;
            rep_bit_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_bit_q <= rep_bit_d;
            fail_q    <= fail_d;
        end
    end

    assign health_fail = fail_q;
`else
    localparam int unused_rep_cutoff = REP_CUTOFF;
    assign health_fail = 1'b0;
`endif

    assign DATA_VALID  = dvld_q && !health_fail;
    assign DATA_OUT    = dout_q;
    assign HEALTH_FAIL = health_fail;

    assign handshake  = DATA_VALID && DATA_READY;
    assign out_free   = !DATA_VALID || handshake;
    assign acc_full   = (cnt_q == CNT_W'(OUT_W));
    assign transfer   = ENABLE && !health_fail && acc_full && out_free;
    // A full accumulator blocked by a pending word drops new bits rather than shifting.
    assign accept_bit = ENABLE && !health_fail && emit_vld && (!acc_full || transfer);

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        dvld_d = dvld_q;
        if (handshake) begin
            dvld_d = 1'b0;
        end
        if (transfer) begin
            dout_d = acc_q;
            dvld_d = 1'b1;
            cnt_d  = '0;
        end
        if (accept_bit) begin
            acc_d = {acc_q[OUT_W-2:0], emit_bit};
            cnt_d = transfer ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end
        if (!ENABLE) begin
            acc_d = '0;
            cnt_d = '0;
        end
        if (health_fail) begin
            dvld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
        end
    end

endmodule

// File: doc/ro_entropy_collector.md
RO_ENTROPY_COLLECTOR -- requirements
Module: ro_entropy_collector

Interface
REQ-001 Parameter N, default 10: number of ring-oscillator inputs sampled.
REQ-002 Parameter OUT_W, default 8: width of each delivered random word.
REQ-003 Parameter REP_CUTOFF, default 32: repetition-test cutoff in consecutive identical raw bits.
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 ENABLE  input  1  collection enable; low halts sampling.
REQ-007 RO_IN  input  N  free-running ring-oscillator outputs, asynchronous to CLK.
REQ-008 DATA_OUT  output  OUT_W  completed random word.
REQ-009 DATA_VALID  output  1  DATA_OUT holds an undelivered word.
REQ-010 DATA_READY  input  1  consumer accepts the word when DATA_VALID && DATA_READY at a rising CLK edge.
REQ-011 HEALTH_FAIL  output  1  sticky entropy-source failure flag.

Function
REQ-012 Each RO_IN bit SHALL pass through a 2-flop synchronizer; raw bit = XOR of all synchronized bits, so an RO_IN change reaches raw 2 cycles later.
REQ-013 While ENABLE=1, one raw bit SHALL be sampled per cycle, alternating pair phase FIRST/SECOND; the first sample after ENABLE rises or after reset is FIRST.
REQ-014 Von Neumann correction on each (FIRST,SECOND) pair: 01 -> emit 0, 10 -> emit 1, 00/11 -> emit nothing.
REQ-015 Emitted bits SHALL shift into an OUT_W accumulator at the LSB ({acc[OUT_W-2:0], bit}) with a bit counter 0..OUT_W.
REQ-016 When the counter reaches OUT_W and the output register is empty or is handed off that cycle, the accumulator SHALL transfer to DATA_OUT, DATA_VALID=1 on the next edge, and the counter clears.
REQ-017 Simultaneous handshake and transfer: new word loads, DATA_VALID stays 1, no bubble, no loss.
REQ-018 Accumulator full while output register holds an unaccepted word: new emitted bits SHALL be discarded; accumulator contents preserved.
REQ-019 DATA_OUT and DATA_VALID SHALL hold stable until handshake; DATA_VALID clears on handshake if no new word transfers.
REQ-020 ENABLE=0: no sampling, pair phase returns to FIRST, counter and accumulator clear; output register and DATA_VALID unaffected.

Reset
REQ-021 RST SHALL asynchronously clear synchronizers, pair phase (FIRST), accumulator, counter, DATA_OUT=0, DATA_VALID=0, HEALTH_FAIL=0, repetition counter=0.
REQ-022 RST asserted mid-word SHALL discard any partial and pending word; the first word after reset contains only post-reset samples.

Configuration
REQ-023 Macro RO_TRNG_HEALTH_EN defined: repetition-count test; REP_CUTOFF consecutive identical raw bits sets HEALTH_FAIL sticky until RST, forces DATA_VALID=0, halts accumulation.
REQ-024 Macro undefined: no test logic, HEALTH_FAIL tied 0, REP_CUTOFF unused.

Structure
REQ-025 Package trng_pkg SHALL hold default N, OUT_W, REP_CUTOFF constants and the pair-phase enumeration; shared with the ring-oscillator generator.
REQ-026 One sub-module von_neumann_corrector (raw bit + sample strobe in, emit-valid + bit out); synchronizer, accumulator, output register and health test stay in the top module.

Verification
REQ-027 Raw sequence 0,1,1,0 repeated, ENABLE=1, DATA_READY=1 -> DATA_OUT=0x55, DATA_VALID pulses once per 16 sampled cycles.
REQ-028 Raw sequence 0,0,1,1 repeated -> no emitted bits, DATA_VALID never asserts.
REQ-029 DATA_READY=0 after first word 0x55, then raw pattern changed to 1,0 repeated -> DATA_OUT holds 0x55; on DATA_READY=1 next word 0xFF follows with no bubble.
REQ-030 ENABLE dropped after 5 emitted bits, re-raised with 0,1 pattern -> next word 0x00 contains no pre-drop bits.
REQ-031 RO_TRNG_HEALTH_EN defined, raw held at 1 for 32 cycles -> HEALTH_FAIL=1, DATA_VALID=0 until RST; RST clears HEALTH_FAIL=0.
REQ-032 RST asserted mid-word and mid-pending-word -> all outputs 0 asynchronously, before the next CLK edge.
